cdb_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the single common data bus (CDB) among `NUM_REQ` functional units (ALU, mult, load, branch). Each FU holds `done` with its result and ROB tag until acknowledged; the arbiter picks one winner per cycle, returns a one-hot `ack`, and registers the winner onto the CDB broadcast register. It sits between the execute-stage FU outputs and the CDB consumers (RS wakeup, ROB complete, map table).

---
 rtl/cdb_rr_arbiter_pkg.sv | 24 ++
 rtl/cdb_rr_arbiter_rr_pick.sv | 40 ++++
 rtl/cdb_rr_arbiter.sv | 70 +++++++
 tb/tb_cdb_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared constants and packet types for the common data bus arbiter.
// Widths here are the machine defaults; the arbiter itself stays parameterised.
package cdb_rr_arbiter_pkg;

   localparam int CDB_NUM_FU = 4;
   localparam int CDB_XLEN   = 32;
   localparam int ROB_TAG_W  = 5;

   typedef logic [ROB_TAG_W-1:0] rob_tag_t;

   // Packing used by the top-level wrapper when bundling FU outputs and the CDB.
   typedef struct packed {
      logic                done;
      rob_tag_t            tag;
      logic [CDB_XLEN-1:0] value;
   } fu_out_packet_t;

   typedef struct packed {
      logic                valid;
      rob_tag_t            tag;
      logic [CDB_XLEN-1:0] value;
   } cdb_packet_t;

endpackage

// File: rtl/cdb_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr,
// found by rotating a doubled request vector and priority-encoding the result.
module rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any
);

   logic [2*NUM_REQ-1:0] dbl_req;
   logic [NUM_REQ-1:0]   rot_req;
   int                   sum;

   // Scanning downward lets the lowest rotated position (closest to ptr) win.
   always_comb begin
      dbl_req    = {req, req};
      rot_req    = NUM_REQ'(dbl_req >> ptr);
      any        = 1'b0;
      gnt_onehot = '0;
      sum        = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot_req[i]) begin
            any = 1'b1;
            sum = int'(ptr) + i;
         end
      end
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end
      gnt_idx = IDX_W'(sum);
      if (any) begin
         gnt_onehot = NUM_REQ'(1) << gnt_idx;
      end
   end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Round-robin arbiter sharing the CDB among the functional units; holds the
// priority pointer and the registered broadcast.
module cdb_rr_arbiter
   import cdb_rr_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = CDB_NUM_FU,
   parameter  int XLEN    = CDB_XLEN,
   parameter  int TAG_W   = $bits(rob_tag_t),
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           clear,
   input  logic                           cdb_stall,
   input  logic [NUM_REQ-1:0]             req_done,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
   input  logic [NUM_REQ-1:0][XLEN-1:0]   req_value,
   output logic [NUM_REQ-1:0]             ack,
   output logic                           cdb_valid,
   output logic [TAG_W-1:0]               cdb_tag,
   output logic [XLEN-1:0]                cdb_value,
   output logic [IDX_W-1:0]               cdb_src
);

   logic [IDX_W-1:0]   ptr;
   logic [NUM_REQ-1:0] gnt_onehot;
   logic [IDX_W-1:0]   gnt_idx;
   logic               any;
   logic               grant_en;
   logic [IDX_W-1:0]   ptr_next;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req        (req_done),
      .ptr        (ptr),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (any)
   );

   // Reset level is folded in so no FU sees an ack while the arbiter is held in reset.
   always_comb begin
      grant_en = reset & ~clear & ~cdb_stall;
      ack      = grant_en ? gnt_onehot : '0;
      ptr_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
   end

   // A stalled broadcast stays on the bus; clear only kills the valid bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_src   <= '0;
      end else if (clear) begin
         cdb_valid <= 1'b0;
      end else if (!cdb_stall) begin
         if (any) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= req_tag[gnt_idx];
            cdb_value <= req_value[gnt_idx];
            cdb_src   <= gnt_idx;
            ptr       <= ptr_next;
         end else begin
            cdb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Scoreboard bench for cdb_rr_arbiter: directed scenarios followed by a
// random run with an FU model that drops done after being acked.
module tb_cdb_rr_arbiter;
   import cdb_rr_arbiter_pkg::*;

   localparam int N  = CDB_NUM_FU;
   localparam int XW = CDB_XLEN;
   localparam int TW = $bits(rob_tag_t);
   localparam int IW = $clog2(N);

   typedef struct {
      logic [TW-1:0] tag;
      logic [XW-1:0] value;
      logic [IW-1:0] src;
   } beat_t;

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic                  clear = 1'b0;
   logic                  cdb_stall = 1'b0;
   logic [N-1:0]          req_done = '0;
   logic [N-1:0][TW-1:0]  req_tag = '0;
   logic [N-1:0][XW-1:0]  req_value = '0;
   logic [N-1:0]          ack;
   logic                  cdb_valid;
   logic [TW-1:0]         cdb_tag;
   logic [XW-1:0]         cdb_value;
   logic [IW-1:0]         cdb_src;

   int           checks = 0;
   int           errors = 0;
   beat_t        sb[$];
   int           m_ptr;
   logic         m_valid;
   beat_t        m_beat;
   int           wait_cnt[N];
   int           max_wait;
   logic [N-1:0] obs_ack;

   cdb_rr_arbiter dut (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .cdb_stall (cdb_stall),
      .req_done  (req_done),
      .req_tag   (req_tag),
      .req_value (req_value),
      .ack       (ack),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_value (cdb_value),
      .cdb_src   (cdb_src)
   );

   always #5 clock = ~clock;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic reset_model();
      m_ptr   = 0;
      m_valid = 1'b0;
      m_beat  = '{tag: '0, value: '0, src: '0};
      sb.delete();
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
   endtask

   task automatic apply_stimulus(input logic [N-1:0] done, input logic stall, input logic clr);
      req_done  = done;
      cdb_stall = stall;
      clear     = clr;
   endtask

   // One clock: check ack mid-cycle against the pointer model, then check the
   // registered broadcast just after the edge against the scoreboard.
   task automatic cycle();
      logic [N-1:0] exp_ack;
      int           w;
      logic         enabled;
      @(negedge clock);
      exp_ack = '0;
      w       = -1;
      enabled = reset && !clear && !cdb_stall;
      if (enabled) begin
         for (int k = 0; k < N; k++) begin
            if (w < 0 && req_done[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         end
      end
      if (w >= 0) exp_ack[w] = 1'b1;
      obs_ack = ack;
      check_output("ack", ack, exp_ack);
      if (enabled) begin
         for (int i = 0; i < N; i++) begin
            if (ack[i]) wait_cnt[i] = 0;
            else if (req_done[i]) begin
               wait_cnt[i]++;
               if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
         end
      end
      if (w >= 0) sb.push_back('{tag: req_tag[w], value: req_value[w], src: IW'(w)});
      @(posedge clock);
      #1;
      if (clear) m_valid = 1'b0;
      else if (!cdb_stall) begin
         m_valid = (w >= 0);
         if (w >= 0) m_ptr = (w + 1) % N;
      end
      check_output("cdb_valid", cdb_valid, m_valid);
      if (w >= 0) begin
         m_beat = sb.pop_front();
         check_output("cdb_tag", cdb_tag, m_beat.tag);
         check_output("cdb_value", cdb_value, m_beat.value);
         check_output("cdb_src", cdb_src, m_beat.src);
      end else if (m_valid) begin
         check_output("hold_tag", cdb_tag, m_beat.tag);
         check_output("hold_value", cdb_value, m_beat.value);
      end
   endtask

   task automatic set_fu(input int i, input int tag, input int value);
      req_tag[i]   = TW'(tag);
      req_value[i] = XW'(value);
   endtask

   initial begin
      logic [N-1:0]  ord[5];
      logic [TW-1:0] fu2_tag;
      logic [XW-1:0] fu2_value;
      max_wait = 0;
      reset_model();
      // Reset state, with requests present to show ack stays low.
      #2;
      apply_stimulus('1, 1'b0, 1'b0);
      #1;
      check_output("rst_ack", ack, 0);
      check_output("rst_valid", cdb_valid, 0);
      check_output("rst_tag", cdb_tag, 0);
      check_output("rst_value", cdb_value, 0);
      check_output("rst_src", cdb_src, 0);
      apply_stimulus('0, 1'b0, 1'b0);
      @(posedge clock);
      #1 reset = 1'b1;

      // Single requester; afterwards the pointer must sit at 2.
      set_fu(1, 3, 250);
      apply_stimulus(4'b0010, 1'b0, 1'b0);
      cycle();
      check_output("single_ack", obs_ack, 4'b0010);
      check_output("single_tag", cdb_tag, 3);
      check_output("single_value", cdb_value, 250);
      check_output("single_src", cdb_src, 1);
      apply_stimulus('0, 1'b0, 1'b0);
      cycle();
      for (int i = 0; i < N; i++) set_fu(i, 8 + i, 1000 + i);
      apply_stimulus('1, 1'b0, 1'b0);
      cycle();
      check_output("ptr_after_single", obs_ack, 4'b0100);

      // Fresh reset, then everyone requests continuously.
      apply_stimulus('0, 1'b0, 1'b0);
      reset = 1'b0;
      #1 reset_model();
      @(posedge clock);
      #1 reset = 1'b1;
      ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      apply_stimulus('1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < N; i++) set_fu(i, 4 * i + k, 32'h100 * k + i);
         cycle();
         check_output("rr_order", obs_ack, ord[k]);
      end

      // FU2 broadcasts, then a 3-cycle stall while FU0 waits; release wraps 3->0.
      set_fu(2, 21, 32'hcafe);
      fu2_tag   = TW'(21);
      fu2_value = XW'(32'hcafe);
      apply_stimulus(4'b0100, 1'b0, 1'b0);
      cycle();
      set_fu(0, 7, 32'h77);
      apply_stimulus(4'b0001, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_output("stall_ack", obs_ack, 0);
         check_output("stall_tag", cdb_tag, fu2_tag);
         check_output("stall_value", cdb_value, fu2_value);
      end
      apply_stimulus(4'b0001, 1'b0, 1'b0);
      cycle();
      check_output("stall_release_wrap", obs_ack, 4'b0001);

      // Clear while FU1 requests and a broadcast is valid; clear beats stall.
      set_fu(1, 12, 32'h1212);
      apply_stimulus(4'b0010, 1'b1, 1'b1);
      cycle();
      check_output("clear_valid", cdb_valid, 0);
      apply_stimulus(4'b0010, 1'b0, 1'b0);
      cycle();
      check_output("after_clear", obs_ack, 4'b0010);

      // Async reset in the middle of a valid broadcast.
      apply_stimulus('0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      check_output("async_valid", cdb_valid, 0);
      check_output("async_tag", cdb_tag, 0);
      check_output("async_value", cdb_value, 0);
      reset_model();
      @(posedge clock);
      #1;
      reset = 1'b1;
      apply_stimulus('1, 1'b0, 1'b0);
      cycle();
      check_output("post_reset_ptr0", obs_ack, 4'b0001);

      // Random traffic; an FU only changes its request once acked or idle.
      max_wait = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int n = 0; n < 1000; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_done[i] || obs_ack[i]) begin
               req_done[i]  = 1'($urandom_range(0, 1));
               req_tag[i]   = TW'($urandom);
               req_value[i] = XW'($urandom);
            end
         end
         cdb_stall = ($urandom_range(0, 4) == 0);
         clear     = ($urandom_range(0, 19) == 0);
         cycle();
      end
      check_output("sb_empty", 64'(sb.size()), 0);
      check_output("fairness", 64'(max_wait < N), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
